// File: rtl/writeback_stage_if.sv
// Retire-side handshake from execute plus the data-memory load response
// consumed by writeback_stage.
interface writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu;
  logic [31:0] in_pc4;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output in_valid, in_rd, in_wb_sel, in_funct3, in_alu, in_pc4,
    output mem_rvalid, mem_rdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_wb_sel, in_funct3, in_alu, in_pc4,
    input  mem_rvalid, mem_rdata,
    output in_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// shrv32 writeback stage: selects the retiring result and drives one registered
// register-file write per instruction. Optional macro WB_RETIRE_CNT_EN adds a retire counter.
//
// state     | meaning
// IDLE      | ready for the next retiring instruction
// WAIT_LOAD | load accepted, waiting for mem_rvalid or timeout
// COMMIT    | write-port cycle (WE high unless suppressed)
module writeback_stage #(
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RST,
  writeback_stage_if.slave   bus,
  output logic               WE,
  output logic [4:0]         A3,
  output logic [31:0]        WB,
  output logic               load_err,
  output logic [31:0]        retire_count
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, COMMIT} state_t;

  localparam logic [15:0] TO_LAST = 16'(LOAD_TIMEOUT - 1);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wb_q, wb_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_q, addr_d;

  logic        load_bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign bus.in_ready = (state_q == IDLE);

  // Illegal width or misaligned address rejects the load at accept time.
  always_comb begin
    load_bad = 1'b0;
    case (bus.in_funct3)
      F3_LB, F3_LBU: load_bad = 1'b0;
      F3_LH, F3_LHU: load_bad = bus.in_alu[0];
      F3_LW:         load_bad = (bus.in_alu[1:0] != 2'b00);
      default:       load_bad = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = bus.mem_rdata[{addr_q, 3'b000} +: 8];
    half_sel = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      F3_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_ext = {24'h0, byte_sel};
      F3_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_ext = {16'h0, half_sel};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    a3_d     = a3_q;
    wb_d     = wb_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rd_d     = bus.in_rd;
          funct3_d = bus.in_funct3;
          addr_d   = bus.in_alu[1:0];
          case (bus.in_wb_sel)
            2'd0, 2'd2: begin
              state_d = COMMIT;
              if (bus.in_rd != 5'd0) begin
                we_d = 1'b1;
                a3_d = bus.in_rd;
                wb_d = (bus.in_wb_sel == 2'd0) ? bus.in_alu : bus.in_pc4;
              end
            end
            2'd1: begin
              if (load_bad) begin
                err_d = 1'b1;
              end else begin
                state_d = WAIT_LOAD;
                cnt_d   = 16'd0;
              end
            end
            default: state_d = COMMIT;
          endcase
        end
      end
      WAIT_LOAD: begin
        // Data arriving on the last allowed cycle still completes the load.
        if (bus.mem_rvalid) begin
          state_d = COMMIT;
          if (rd_q != 5'd0) begin
            we_d = 1'b1;
            a3_d = rd_q;
            wb_d = load_ext;
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      a3_q     <= 5'd0;
      wb_q     <= 32'd0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
      rd_q     <= 5'd0;
      funct3_q <= 3'd0;
      addr_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      a3_q     <= a3_d;
      wb_q     <= wb_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
    end
  end

  assign WE       = we_q;
  assign A3       = a3_q;
  assign WB       = wb_q;
  assign load_err = err_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q + 32'((state_q == COMMIT) ? 1 : 0);
  end

  always_ff @(posedge CLK) begin
    if (!RST) retire_q <= 32'd0;
    else      retire_q <= retire_d;
  end

  assign retire_count = retire_q;
`else
  assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage (LOAD_TIMEOUT = 4): table of retire
// vectors plus hand sequences for reset, latency, stray data and mid-load reset.
module tb_writeback_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WE;
  logic [4:0]  A3;
  logic [31:0] WB;
  logic        load_err;
  logic [31:0] retire_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_retire = 32'd0;

  writeback_stage_if bus ();

  writeback_stage #(.LOAD_TIMEOUT(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus),
    .WE           (WE),
    .A3           (A3),
    .WB           (WB),
    .load_err     (load_err),
    .retire_count (retire_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    int          rv;       // interval in which mem_rvalid is driven (0 = never)
    logic        exp_we;
    int          exp_cyc;  // interval of the WE or load_err pulse
    logic [4:0]  exp_a3;
    logic [31:0] exp_wb;
    logic        exp_err;
    logic        exp_rdy1;
    logic        retire;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_retire();
`ifdef WB_RETIRE_CNT_EN
    return model_retire;
`else
    return 32'd0;
`endif
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge CLK);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          we_n = 0, err_n = 0, we_cyc = -1, err_cyc = -1;
    logic [4:0]  a3_s = '0;
    logic [31:0] wb_s = '0;
    logic        rdy1 = 1'b0;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_wb_sel = v.sel;
    bus.in_funct3 = v.f3;
    bus.in_rd     = v.rd;
    bus.in_alu    = v.alu;
    bus.in_pc4    = v.pc4;
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      bus.mem_rvalid = (v.rv == c);
      bus.mem_rdata  = v.rdata;
      @(negedge CLK);
      if (c == 1) rdy1 = bus.in_ready;
      if (WE) begin we_n++; we_cyc = c; a3_s = A3; wb_s = WB; end
      if (load_err) begin err_n++; err_cyc = c; end
      @(posedge CLK); #1;
    end
    bus.mem_rvalid = 1'b0;
    if (v.retire) model_retire++;
    chk({tag, "_we_count"},  32'(we_n),  32'(v.exp_we));
    chk({tag, "_err_count"}, 32'(err_n), 32'(v.exp_err));
    chk({tag, "_ready1"},    {31'd0, rdy1}, {31'd0, v.exp_rdy1});
    if (v.exp_we) begin
      chk({tag, "_we_cycle"}, 32'(we_cyc), 32'(v.exp_cyc));
      chk({tag, "_a3"}, {27'd0, a3_s}, {27'd0, v.exp_a3});
      chk({tag, "_wb"}, wb_s, v.exp_wb);
    end
    if (v.exp_err) chk({tag, "_err_cycle"}, 32'(err_cyc), 32'(v.exp_cyc));
    chk({tag, "_retire"}, retire_count, exp_retire());
  endtask

  initial begin
    int we_seen;
    //             sel   f3      rd     alu           pc4          rdata        rv we cyc a3     wb            err  rdy1 ret
    vecs[0]  = '{2'd0, 3'b000, 5'd5,  32'h12345678, 32'h0,       32'h0,       0, 1, 1, 5'd5,  32'h12345678, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{2'd2, 3'b000, 5'd0,  32'h0,        32'h104,     32'h0,       0, 0, 0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1};
    vecs[2]  = '{2'd2, 3'b000, 5'd31, 32'hDEAD,     32'h200,     32'h0,       0, 1, 1, 5'd31, 32'h200,      1'b0, 1'b0, 1'b1};
    vecs[3]  = '{2'd3, 3'b000, 5'd7,  32'h55,       32'h66,      32'h0,       0, 0, 0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1};
    vecs[4]  = '{2'd1, 3'b000, 5'd10, 32'h1003,     32'h0,       32'h80FF0000,1, 1, 2, 5'd10, 32'hFFFFFF80, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{2'd1, 3'b100, 5'd11, 32'h1003,     32'h0,       32'h80FF0000,1, 1, 2, 5'd11, 32'h00000080, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{2'd1, 3'b001, 5'd12, 32'h1002,     32'h0,       32'h80010000,2, 1, 3, 5'd12, 32'hFFFF8001, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{2'd1, 3'b101, 5'd13, 32'h1000,     32'h0,       32'h1234F00F,3, 1, 4, 5'd13, 32'h0000F00F, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{2'd1, 3'b010, 5'd14, 32'h1004,     32'h0,       32'hCAFEBABE,4, 1, 5, 5'd14, 32'hCAFEBABE, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{2'd1, 3'b000, 5'd15, 32'h1001,     32'h0,       32'h00007F00,1, 1, 2, 5'd15, 32'h0000007F, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{2'd1, 3'b010, 5'd16, 32'h1002,     32'h0,       32'h11111111,1, 0, 1, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0};
    vecs[11] = '{2'd1, 3'b001, 5'd17, 32'h1001,     32'h0,       32'h11111111,1, 0, 1, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0};
    vecs[12] = '{2'd1, 3'b011, 5'd18, 32'h1000,     32'h0,       32'h11111111,1, 0, 1, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0};
    vecs[13] = '{2'd1, 3'b110, 5'd19, 32'h1000,     32'h0,       32'h11111111,1, 0, 1, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0};
    vecs[14] = '{2'd1, 3'b010, 5'd9,  32'h2000,     32'h0,       32'h22222222,0, 0, 5, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    vecs[15] = '{2'd1, 3'b000, 5'd0,  32'h1000,     32'h0,       32'h000000AB,1, 0, 0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1};
    vecs[16] = '{2'd1, 3'b101, 5'd20, 32'h1003,     32'h0,       32'h11111111,1, 0, 1, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0};

    RST            = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_rd      = '0;
    bus.in_wb_sel  = '0;
    bus.in_funct3  = '0;
    bus.in_alu     = '0;
    bus.in_pc4     = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_we",       {31'd0, WE}, 32'd0);
    chk("reset_a3",       {27'd0, A3}, 32'd0);
    chk("reset_wb",       WB, 32'd0);
    chk("reset_load_err", {31'd0, load_err}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_retire",   retire_count, 32'd0);
    RST = 1'b1;

    // ALU latency: WE only in the interval after accept, ready again one later.
    wait_ready();
    bus.in_valid = 1'b1; bus.in_wb_sel = 2'd0; bus.in_rd = 5'd6; bus.in_alu = 32'hA5A5_0001;
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    @(negedge CLK);
    chk("lat_we_n1",    {31'd0, WE}, 32'd1);
    chk("lat_ready_n1", {31'd0, bus.in_ready}, 32'd0);
    chk("lat_wb_n1",    WB, 32'hA5A5_0001);
    @(negedge CLK);
    chk("lat_we_n2",    {31'd0, WE}, 32'd0);
    chk("lat_ready_n2", {31'd0, bus.in_ready}, 32'd1);
    chk("lat_wb_hold",  WB, 32'hA5A5_0001);
    model_retire++;
    @(negedge CLK);
    chk("lat_retire",   retire_count, exp_retire());

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Stray load data while idle must not write.
    wait_ready();
    we_seen = 0;
    for (int c = 0; c < 4; c++) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h3333_3333;
      @(posedge CLK); #1;
      @(negedge CLK);
      if (WE) we_seen++;
    end
    bus.mem_rvalid = 1'b0;
    chk("stray_rvalid_we", 32'(we_seen), 32'd0);
    chk("stray_rvalid_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("stray_rvalid_retire", retire_count, exp_retire());

    // Reset while waiting for load data.
    wait_ready();
    bus.in_valid = 1'b1; bus.in_wb_sel = 2'd1; bus.in_funct3 = 3'b010;
    bus.in_rd = 5'd3; bus.in_alu = 32'h3000;
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    @(negedge CLK);
    chk("midrst_ready_wait", {31'd0, bus.in_ready}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("midrst_we",       {31'd0, WE}, 32'd0);
    chk("midrst_load_err", {31'd0, load_err}, 32'd0);
    chk("midrst_ready",    {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_a3",       {27'd0, A3}, 32'd0);
    chk("midrst_wb",       WB, 32'd0);
    chk("midrst_retire",   retire_count, 32'd0);
    model_retire = 32'd0;
    RST = 1'b1;
    we_seen = 0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h4444_4444;
    @(posedge CLK); #1;
    bus.mem_rvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (WE || load_err) we_seen++;
    end
    chk("midrst_late_data", 32'(we_seen), 32'd0);

    run_vec(100, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
